// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcode encoding, flag bundle and control states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS_A = 4'h0,
        OP_PASS_B = 4'h1,
        OP_SHL1   = 4'h2,
        OP_SHR1   = 4'h3,
        OP_ADD    = 4'h4,
        OP_SUB    = 4'h5,
        OP_AND    = 4'h6,
        OP_OR     = 4'h7,
        OP_XOR    = 4'h8,
        OP_NOT    = 4'h9,
        OP_MUL    = 4'hA
    } op_e;

    typedef struct packed {
        logic illegal;
        logic ovf;
        logic carry;
        logic neg;
        logic zero;
    } flags_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: retires one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    // done is asserted during the last step so the product is ready on the same edge
    assign done  = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign prod  = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides: single-cycle ops land in the output register on
// the accept edge, MUL goes through the sequential multiplier. One operation in flight at a time.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output flags_t           flags
);
    state_e             state_q, state_d;
    logic               init_q;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    flags_t             flags_q, flags_d;

    logic [WIDTH:0]     sum_w, dif_w;
    logic [WIDTH-1:0]   alu_y;
    flags_t             alu_f;
    logic               legal;

    logic               is_mul, accept, drain, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    flags_t             mul_f;

    // init_q keeps in_ready low until the first edge after reset release
    assign in_ready  = init_q && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign is_mul    = (op == OP_MUL);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid_q && out_ready;
    assign mul_start = accept && is_mul;

    always_comb begin
        sum_w = {1'b0, a} + {1'b0, b};
        dif_w = {1'b0, a} - {1'b0, b};
        alu_y = '0;
        alu_f = '0;
        legal = 1'b1;
        case (op)
            OP_PASS_A: alu_y = a;
            OP_PASS_B: alu_y = b;
            OP_SHL1: begin
                alu_y       = {a[WIDTH-2:0], 1'b0};
                alu_f.carry = a[WIDTH-1];
            end
            OP_SHR1: begin
                alu_y       = {1'b0, a[WIDTH-1:1]};
                alu_f.carry = a[0];
            end
            OP_ADD: begin
                alu_y       = sum_w[WIDTH-1:0];
                alu_f.carry = sum_w[WIDTH];
                alu_f.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y       = dif_w[WIDTH-1:0];
                alu_f.carry = dif_w[WIDTH];
                alu_f.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_NOT:  alu_y = ~a;
            OP_MUL:  alu_y = '0;
            default: legal = 1'b0;
        endcase
        if (legal) begin
            alu_f.zero = (alu_y == '0);
            alu_f.neg  = alu_y[WIDTH-1];
        end else begin
            alu_f.illegal = 1'b1;
            alu_f.zero    = 1'b1;
        end
    end

    always_comb begin
        mul_f       = '0;
        mul_f.carry = |mul_prod[2*WIDTH-1:WIDTH];
        mul_f.zero  = (mul_prod[WIDTH-1:0] == '0);
        mul_f.neg   = mul_prod[WIDTH-1];
    end

    // MUL is only accepted once the output slot is free or draining, so completion never clobbers
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        flags_d     = flags_q;
        if (drain) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = MUL_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        y_d         = alu_y;
                        flags_d     = alu_f;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    y_d         = mul_prod[WIDTH-1:0];
                    flags_d     = mul_f;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk  (clk),
        .rst_n(rst_n),
        .start(mul_start),
        .a    (a),
        .b    (b),
        .done (mul_done),
        .prod (mul_prod)
    );

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=8: directed vector table, handshake/reset sequences, random ops vs model.
module tb_alu_pipe;
    import alu_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   y;
    flags_t       flags;

    int n_chk  = 0;
    int n_pass = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] y;
        logic [4:0] f;
        int         edges;
        string      nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference: {y[7:0], illegal, ovf, carry, neg, zero} from plain integer arithmetic
    function automatic logic [12:0] model(input int unsigned ma, input int unsigned mb,
                                          input int unsigned mop);
        int unsigned r;
        int          sa, sb, s;
        logic        c, v, il;
        c = 1'b0; v = 1'b0; il = 1'b0; r = 0; s = 0;
        sa = (ma >= 128) ? int'(ma) - 256 : int'(ma);
        sb = (mb >= 128) ? int'(mb) - 256 : int'(mb);
        case (mop)
            0:  r = ma;
            1:  r = mb;
            2:  begin r = (ma * 2) % 256; c = (ma >= 128); end
            3:  begin r = ma / 2; c = ((ma % 2) == 1); end
            4:  begin r = (ma + mb) % 256; c = ((ma + mb) > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            5:  begin r = (ma + 256 - mb) % 256; c = (ma < mb); s = sa - sb; v = (s > 127) || (s < -128); end
            6:  r = ma & mb;
            7:  r = ma | mb;
            8:  r = ma ^ mb;
            9:  r = 255 - ma;
            10: begin r = (ma * mb) % 256; c = ((ma * mb) > 255); end
            default: il = 1'b1;
        endcase
        return {r[7:0], il, v, c, (il ? 1'b0 : (r >= 128)), (r == 0)};
    endfunction

    // Issue one op (called just after a clock edge), measure accept-to-result edges, optionally stall
    task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [3:0] top, input logic [7:0] ey, input logic [4:0] ef,
                         input int eedges, input int stall);
        int guard, e, busy;
        out_ready = (stall == 0);
        a = ta; b = tb_; op = top; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            chk({nm, " accept timeout"}, 32'(in_ready), 32'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = 0; busy = 0;
        while (!out_valid && e < 40) begin
            if (!in_ready) busy++;
            @(posedge clk); #1;
            e++;
        end
        chk({nm, " out_valid"}, 32'(out_valid), 32'(1));
        chk({nm, " y"}, 32'(y), 32'(ey));
        chk({nm, " flags"}, 32'(flags), 32'(ef));
        chk({nm, " edges"}, 32'(e), 32'(eedges));
        chk({nm, " busy cycles"}, 32'(busy), 32'(eedges));
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            chk({nm, " stall hold"}, 32'({out_valid, y, flags, in_ready}), 32'({1'b1, ey, ef, 1'b0}));
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({nm, " drained"}, 32'(out_valid), 32'(0));
    endtask

    vec_t tbl[16];

    initial begin
        logic [7:0]  ra, rb;
        logic [3:0]  rop;
        logic [12:0] m;
        logic [12:0] expq[$];
        logic [7:0]  bba[6];
        logic [7:0]  bbb[6];
        logic [3:0]  bbo[6];
        int          cnt;

        tbl[0]  = '{8'h55, 8'h02, 4'h0, 8'h55, 5'b00000, 0, "pass_a"};
        tbl[1]  = '{8'h55, 8'h02, 4'h1, 8'h02, 5'b00000, 0, "pass_b"};
        tbl[2]  = '{8'h55, 8'h02, 4'h2, 8'hAA, 5'b00010, 0, "shl1"};
        tbl[3]  = '{8'h7F, 8'h01, 4'h4, 8'h80, 5'b01010, 0, "add ovf"};
        tbl[4]  = '{8'h02, 8'h55, 4'h5, 8'hAD, 5'b00110, 0, "sub borrow"};
        tbl[5]  = '{8'hFF, 8'h01, 4'h4, 8'h00, 5'b00101, 0, "add wrap"};
        tbl[6]  = '{8'h55, 8'h02, 4'hA, 8'hAA, 5'b00010, 8, "mul 55x02"};
        tbl[7]  = '{8'h10, 8'h10, 4'hA, 8'h00, 5'b00101, 8, "mul 10x10"};
        tbl[8]  = '{8'h55, 8'h02, 4'hF, 8'h00, 5'b10001, 0, "illegal f"};
        tbl[9]  = '{8'h55, 8'h00, 4'h3, 8'h2A, 5'b00100, 0, "shr1"};
        tbl[10] = '{8'hF0, 8'h3C, 4'h6, 8'h30, 5'b00000, 0, "and"};
        tbl[11] = '{8'hF0, 8'h0F, 4'h7, 8'hFF, 5'b00010, 0, "or"};
        tbl[12] = '{8'hAA, 8'hAA, 4'h8, 8'h00, 5'b00001, 0, "xor"};
        tbl[13] = '{8'h00, 8'h00, 4'h9, 8'hFF, 5'b00010, 0, "not"};
        tbl[14] = '{8'h80, 8'h01, 4'h5, 8'h7F, 5'b01000, 0, "sub ovf"};
        tbl[15] = '{8'hFF, 8'hFF, 4'hA, 8'h01, 5'b00100, 8, "mul ffxff"};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'({out_valid, y, flags, in_ready}), 32'(0));
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        chk("in_ready after release", 32'(in_ready), 32'(1));

        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].y, tbl[i].f, tbl[i].edges, 0);
        end

        // Backpressure: result held 5 cycles while a new op waits, then drain+accept together
        out_ready = 1'b0;
        a = 8'h03; b = 8'h04; op = 4'h4; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h00; b = 8'h99; op = 4'h1;
        for (int i = 0; i < 5; i++) begin
            chk("bp hold", 32'({out_valid, y, flags, in_ready}), 32'({1'b1, 8'h07, 5'b00000, 1'b0}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready with out_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp drain+accept", 32'({out_valid, y, flags}), 32'({1'b1, 8'h99, 5'b00010}));
        @(posedge clk); #1;
        chk("bp final drain", 32'(out_valid), 32'(0));

        // Reset while the multiplier is busy
        a = 8'h55; b = 8'h02; op = 4'hA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid-mul busy", 32'({out_valid, in_ready, y}), 32'({1'b0, 1'b0, 8'h99}));
        rst_n = 1'b0;
        #1;
        chk("mid-mul reset", 32'({out_valid, y, flags, in_ready}), 32'(0));
        #2;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("no stale mul result", 32'(cnt), 32'(0));
        do_op("post-reset add", 8'h01, 8'h01, 4'h4, 8'h02, 5'b00000, 0, 0);

        // Back-to-back single-cycle ops, one result per cycle in order
        bba = '{8'h10, 8'h05, 8'h3C, 8'h00, 8'h81, 8'h5A};
        bbb = '{8'h20, 8'h09, 8'h0F, 8'h77, 8'h00, 8'h00};
        bbo = '{4'h4, 4'h5, 4'h8, 4'h1, 4'h2, 4'h9};
        for (int k = 0; k < 6; k++) expq.push_back(model(32'(bba[k]), 32'(bbb[k]), 32'(bbo[k])));
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a = bba[k]; b = bbb[k]; op = bbo[k]; in_valid = 1'b1;
            #1;
            chk("b2b in_ready", 32'(in_ready), 32'(1));
            @(posedge clk); #1;
            m = expq.pop_front();
            chk("b2b result", 32'({out_valid, y, flags}), 32'({1'b1, m}));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b drained", 32'(out_valid), 32'(0));

        // Random ops with random stalls against the model
        for (int i = 0; i < 150; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            m   = model(32'(ra), 32'(rb), 32'(rop));
            do_op("rand", ra, rb, rop, m[12:5], m[4:0], (rop == 4'hA) ? 8 : 0,
                  int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
